// File: rtl/clocks_pkg.sv
//------------------------------------------------------------------------------
// Module : clocks_pkg
// Brief  : Shared widths and types for the clocks_gen divider channels.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package clocks_pkg;
  localparam int CNT_W  = 12;
  localparam int DUTY_W = 4;
  localparam int NUM_CH = 4;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [DUTY_W-1:0] duty_t;

  function automatic cnt_t duty_ext(input duty_t d);
    return {{(CNT_W-DUTY_W){1'b0}}, d};
  endfunction
endpackage

`default_nettype wire

// File: rtl/clocks_gen_if.sv
//------------------------------------------------------------------------------
// Module : clocks_gen_if
// Brief  : Period/duty controls and divided outputs of the four channels.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface clocks_gen_if;
  import clocks_pkg::*;

  cnt_t  period, period1, period2, period3;
  duty_t duty, duty1, duty2, duty3;
  logic  clk0, clk1, clk2, clk3;

  modport master (
    output period, period1, period2, period3,
    output duty, duty1, duty2, duty3,
    input  clk0, clk1, clk2, clk3
  );

  modport slave (
    input  period, period1, period2, period3,
    input  duty, duty1, duty2, duty3,
    output clk0, clk1, clk2, clk3
  );
endinterface

`default_nettype wire

// File: rtl/clock_div_channel.sv
//------------------------------------------------------------------------------
// Module : clock_div_channel
// Brief  : One programmable divider: period P+1 cycles, high time min(D,P+1).
//          Optional CLKS_PHASE_RESTART_EN restarts the waveform on P/D change.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clock_div_channel
  import clocks_pkg::*;
(
  input  wire   clk,
  input  wire   rst,
  input  cnt_t  period,
  input  duty_t duty,
  output logic  clk_out
);

  cnt_t cnt_q, cnt_d;
  logic q_q, q_d;

`ifdef CLKS_PHASE_RESTART_EN
  cnt_t  prev_period_q;
  duty_t prev_duty_q;

  // Reset captures the live settings so the first post-reset edge is no restart.
  always_ff @(posedge clk) begin
    prev_period_q <= period;
    prev_duty_q   <= duty;
  end
`endif

  always_comb begin
    // The >= compare lets a lowered period wrap immediately instead of stalling.
    cnt_d = (cnt_q >= period) ? '0 : cnt_q + 1'b1;
    q_d   = (cnt_q < duty_ext(duty));
`ifdef CLKS_PHASE_RESTART_EN
    if ((prev_period_q != period) || (prev_duty_q != duty)) begin
      cnt_d = '0;
      q_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign clk_out = q_q;

endmodule

`default_nettype wire

// File: rtl/clocks_gen.sv
//------------------------------------------------------------------------------
// Module : clocks_gen
// Brief  : Four independent divider channels sharing one clock and reset.
//          Option macro: CLKS_PHASE_RESTART_EN (per-channel restart on change).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clocks_gen
  import clocks_pkg::*;
(
  input  wire          clk,
  input  wire          rst,
  clocks_gen_if.slave  bus
);

  cnt_t              w_period [NUM_CH];
  duty_t             w_duty   [NUM_CH];
  logic [NUM_CH-1:0] w_clk;

  assign w_period[0] = bus.period;
  assign w_period[1] = bus.period1;
  assign w_period[2] = bus.period2;
  assign w_period[3] = bus.period3;
  assign w_duty[0]   = bus.duty;
  assign w_duty[1]   = bus.duty1;
  assign w_duty[2]   = bus.duty2;
  assign w_duty[3]   = bus.duty3;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clock_div_channel u_ch (
        .clk     (clk),
        .rst     (rst),
        .period  (w_period[i]),
        .duty    (w_duty[i]),
        .clk_out (w_clk[i])
      );
    end
  endgenerate

  assign bus.clk0 = w_clk[0];
  assign bus.clk1 = w_clk[1];
  assign bus.clk2 = w_clk[2];
  assign bus.clk3 = w_clk[3];

endmodule

`default_nettype wire

// File: tb/tb_clocks_gen.sv
//------------------------------------------------------------------------------
// Module : tb_clocks_gen
// Brief  : Scoreboard bench for clocks_gen; expected per-edge outputs queued.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clocks_gen;
  import clocks_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clocks_gen_if bus ();

  clocks_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] exp;
    logic [3:0] mask;
    int         tid;
  } item_t;

  item_t sb[$];
  string names [7] = '{"reset", "p3d3", "duty_step", "mixed_period",
                       "period_wrap", "p_zero", "mid_reset"};
  int errors = 0;
  int checks = 0;

  // Expected high for the k-th edge of a free-running pattern
  function automatic logic hi(input int k, input int per, input int d);
    return (k % per) < d;
  endfunction

  task automatic step(input logic [3:0] e, input logic [3:0] m, input int t);
    item_t it;
    it.exp = e; it.mask = m; it.tid = t;
    sb.push_back(it);
    @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input cnt_t p, input duty_t d);
    case (ch)
      0: begin bus.period  = p; bus.duty  = d; end
      1: begin bus.period1 = p; bus.duty1 = d; end
      2: begin bus.period2 = p; bus.duty2 = d; end
      default: begin bus.period3 = p; bus.duty3 = d; end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(4'h0, 4'hF, 0);
    rst = 1'b0;
  endtask

  // Monitor: one output vector per rising edge, compared away from the edge
  initial begin
    item_t it;
    logic [3:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        it  = sb.pop_front();
        got = {bus.clk3, bus.clk2, bus.clk1, bus.clk0};
        if (it.mask != 4'h0) begin
          checks++;
          if (((got ^ it.exp) & it.mask) != 4'h0) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b (mask %b)",
                     names[it.tid], $time, got, it.exp, it.mask);
          end
        end
      end
    end
  end

  initial begin
    int dvals [5] = '{0, 1, 2, 4, 6};
    logic [3:0] e;
    for (int c = 0; c < 4; c++) set_ch(c, 12'd3, 4'd3);
    rst = 1'b1;
    step(4'h0, 4'hF, 0);
    step(4'h0, 4'hF, 0);
    rst = 1'b0;
    // All channels P=3 D=3 in phase: 1,1,1,0
    for (int k = 0; k < 16; k++) step({4{hi(k, 4, 3)}}, 4'hF, 1);

    // Channel 0 duty stepping, others P=3 D=2
    for (int c = 1; c < 4; c++) set_ch(c, 12'd3, 4'd2);
    set_ch(0, 12'd3, 4'd0);
    do_reset();
    for (int k = 0; k < 500; k++) begin
      bus.duty = duty_t'(dvals[k / 100]);
      e = {{3{hi(k, 4, 2)}}, hi(k, 4, dvals[k / 100])};
      step(e, 4'hF, 2);
    end

    // Channel 1 P=9 D=5 alongside P=3 D=2
    set_ch(0, 12'd3, 4'd2);
    set_ch(1, 12'd9, 4'd5);
    do_reset();
    for (int k = 0; k < 40; k++) begin
      e = {hi(k, 4, 2), hi(k, 4, 2), hi(k, 10, 5), hi(k, 4, 2)};
      step(e, 4'hF, 3);
    end

    // Lower P0 from 9 to 2 while its counter sits at 8
    set_ch(0, 12'd9, 4'd2);
    set_ch(1, 12'd3, 4'd2);
    do_reset();
    for (int k = 0; k < 8; k++) step({3'b000, hi(k, 10, 2)}, 4'h1, 4);
    bus.period = 12'd2;
    step(4'h0, 4'h1, 4);
    for (int k = 0; k < 12; k++) step({3'b000, hi(k, 3, 2)}, 4'h1, 4);

    // P2=0: duty 1 gives constant high, duty 0 constant low
    set_ch(0, 12'd3, 4'd2);
    set_ch(2, 12'd0, 4'd1);
    do_reset();
    for (int k = 0; k < 10; k++) step({hi(k, 4, 2), 1'b1, hi(k, 4, 2), hi(k, 4, 2)}, 4'hF, 5);
    bus.duty2 = 4'd0;
    for (int k = 10; k < 20; k++) step({hi(k, 4, 2), 1'b0, hi(k, 4, 2), hi(k, 4, 2)}, 4'hF, 5);

    // Mid-period reset with P=5 D=3
    for (int c = 0; c < 4; c++) set_ch(c, 12'd5, 4'd3);
    do_reset();
    for (int k = 0; k < 8; k++) step({4{hi(k, 6, 3)}}, 4'hF, 6);
    rst = 1'b1;
    step(4'h0, 4'hF, 6);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) step({4{hi(k, 6, 3)}}, 4'hF, 6);

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
